// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter_pkg
//  Description : Shared constants for the period meter. Holds the FSM state
//                encoding, the default parameter values and a busy decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

    localparam int WIDTH_DEFAULT       = 24;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_MEASURE = 2'd2;

    // Busy covers both the waiting-for-first-edge and the counting phases.
    function automatic logic is_busy(input state_t st);
        return (st == ST_ARMED) || (st == ST_MEASURE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/period_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter_if
//  Description : Control and result bundle of the period meter. The master
//                side drives enable and the signal under test; the slave
//                (the meter) returns the measurement and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             busy;
    logic             timeout;

    modport master (
        output en, sig_in,
        input  period, period_valid, busy, timeout
    );

    modport slave (
        input  en, sig_in,
        output period, period_valid, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/period_meter_sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Multi-flop synchronizer for an asynchronous input followed by
//                a rising-edge detector. The chain clears on reset, so an
//                input that is already high afterwards yields one rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    // Shift the asynchronous input through the chain and remember the last
    // synchronized level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d_async};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign level = r_chain[SYNC_STAGES-1];
    assign rise  = r_chain[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter
//  Description : Measures the rising-edge-to-rising-edge period of a slow
//                asynchronous square wave in clk cycles. Emits a one-cycle
//                valid strobe per measurement and a sticky timeout when no
//                edge arrives before the counter saturates.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    period_meter_if.slave  bus
);
    localparam logic [WIDTH-1:0] c_CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_CNT_ONE = WIDTH'(1);

    logic             w_level;
    logic             w_rise_raw;
    logic             w_rise;

    state_t           r_state;
    state_t           w_state_next;

    logic             w_start;
    logic             w_capture;
    logic             w_expire;
    logic             w_clear;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_busy;
    logic             r_timeout;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (bus.sig_in),
        .level   (w_level),
        .rise    (w_rise_raw)
    );

    // A rise is by construction coincident with a high synchronized level.
    assign w_rise = w_rise_raw & w_level;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; dropping enable always returns to idle.
    always_comb begin
        w_state_next = r_state;
        if (!bus.en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_ARMED;
                ST_ARMED:   if (w_rise) w_state_next = ST_MEASURE;
                ST_MEASURE: if (!w_rise && (r_count == c_CNT_MAX)) w_state_next = ST_ARMED;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath control strobes derived from state and the edge; a rise on the
    // saturating cycle is captured rather than treated as a timeout.
    always_comb begin
        w_clear   = !bus.en;
        w_start   = bus.en && (r_state == ST_ARMED)   && w_rise;
        w_capture = bus.en && (r_state == ST_MEASURE) && w_rise;
        w_expire  = bus.en && (r_state == ST_MEASURE) && !w_rise && (r_count == c_CNT_MAX);
    end

    // Counter, result and status registers; busy tracks the next state so it
    // changes together with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= w_capture;
            r_busy  <= is_busy(w_state_next);
            if (w_clear) begin
                r_count   <= '0;
                r_timeout <= 1'b0;
            end else if (w_start) begin
                r_count   <= c_CNT_ONE;
                r_timeout <= 1'b0;
            end else if (w_capture) begin
                r_period <= r_count;
                r_count  <= c_CNT_ONE;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
                r_count   <= '0;
            end else if (r_state == ST_MEASURE) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign bus.period       = r_period;
    assign bus.period_valid = r_valid;
    assign bus.busy         = r_busy;
    assign bus.timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_period_meter
//  Description : Self-checking bench for period_meter. A timestamp-based
//                reference model predicts status flags and pushes expected
//                periods into a scoreboard queue; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_period_meter;

    localparam int W    = 6;
    localparam int S    = 2;
    localparam int MAXC = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   checking = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    // Samples of sig_in as seen at each edge; rise at edge n means the input
    // was low at edge n-S-1 and high at edge n-S.
    bit   hist [0:S];
    int   cyc      = 0;
    bit   m_idle   = 1'b1;
    bit   m_ref    = 1'b0;
    int   t_ref    = 0;
    bit   m_to     = 1'b0;
    bit   m_valid  = 1'b0;
    int   m_period = 0;
    int   exp_q [$];

    always @(posedge clk) begin
        bit rise;
        cyc++;
        rise    = hist[S-1] & ~hist[S];
        m_valid = 1'b0;
        if (rst) begin
            for (int k = 0; k <= S; k++) hist[k] = 1'b0;
            m_idle   = 1'b1;
            m_ref    = 1'b0;
            m_to     = 1'b0;
            m_period = 0;
        end else begin
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = bus.sig_in;
            if (!bus.en) begin
                m_idle = 1'b1;
                m_ref  = 1'b0;
                m_to   = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (!m_ref) begin
                if (rise) begin
                    m_ref = 1'b1;
                    t_ref = cyc;
                    m_to  = 1'b0;
                end
            end else if (rise) begin
                exp_q.push_back(cyc - t_ref);
                m_period = cyc - t_ref;
                m_valid  = 1'b1;
                t_ref    = cyc;
            end else if (cyc - t_ref == MAXC) begin
                m_to  = 1'b1;
                m_ref = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("busy",         int'(bus.busy),         int'(!m_idle));
            check("timeout",      int'(bus.timeout),      int'(m_to));
            check("period_valid", int'(bus.period_valid), int'(m_valid));
            check("period_held",  int'(bus.period),       m_period);
            if (bus.period_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    check("period", int'(bus.period), exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int n);
        bus.sig_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic square(input int hi, input int lo, input int reps);
        repeat (reps) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        bit lvl;
        int half;
        bus.en     = 1'b0;
        bus.sig_in = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1 checking = 1'b1;
        repeat (2) @(negedge clk);

        // Steady period 10.
        rst    = 1'b0;
        bus.en = 1'b1;
        square(5, 5, 8);
        // Change to 37.
        square(18, 19, 5);
        // One rise then silence well beyond saturation, then period 20.
        drive(1'b1, 3);
        drive(1'b0, 2 * MAXC);
        square(10, 10, 4);
        // Minimum period.
        square(1, 1, 6);
        // Enable dropped on the cycle the rise reaches the meter.
        square(6, 6, 3);
        bus.sig_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        drive(1'b1, 2);
        drive(1'b0, 6);
        square(7, 7, 4);
        // Reset mid-measurement with sig_in high and enable held.
        drive(1'b1, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5);
        square(6, 6, 3);
        // Divider loopback: toggle every 16 cycles.
        square(16, 16, 6);
        // Rises exactly at saturation distance, then one cycle beyond.
        square(1, MAXC - 1, 4);
        square(1, MAXC, 3);

        // Randomized phase.
        lvl  = 1'b0;
        half = $urandom_range(1, 40);
        for (int c = 0; c < 3000; c++) begin
            if (half == 0) begin
                lvl  = ~lvl;
                half = $urandom_range(1, 40);
            end
            half--;
            bus.sig_in = lvl;
            rst = ($urandom_range(0, 399) == 0);
            if (bus.en) begin
                if ($urandom_range(0, 99) == 0) bus.en = 1'b0;
            end else begin
                if ($urandom_range(0, 4) == 0) bus.en = 1'b1;
            end
            @(negedge clk);
        end

        rst        = 1'b0;
        bus.sig_in = 1'b0;
        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
